// File: rtl/dcache_flush_wb.sv
// -----------------------------------------------------------------------------
// dcache_flush_wb
//   Dirty-line writeback/flush engine for the D-cache. On a flush request it
//   walks every tag location in index order. Each valid+dirty line is read
//   from data memory beat by beat, written to the bus, and then has its dirty
//   bit cleared through the tag update port. When the walk is complete, the
//   tag FIFO pointers are reset with a one-cycle fifo_flush pulse.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   flush_req                  start a flush (sampled only while idle)
//   flush_busy                 high whenever the engine is not idle
//   flush_done, fifo_flush     one-cycle pulses at the end of a flush
//   tag_rptr                   tag location being examined
//   tag_rvalid/rdirty/rtag     combinational contents of tag_mem[tag_rptr]
//   tag_uwr/uptr/utag          tag update strobe/location/tag; the update
//                              writes {valid=1,dirty=0,tag_utag}
//   dmem_rd/raddr              data memory read; data arrives one cycle later
//   dmem_rdata                 data memory read data
//   wb_stb/we/adr/dat          write-only bus master, request held until ack
//   wb_ack                     bus accept for the current beat
// -----------------------------------------------------------------------------
module dcache_flush_wb #(
  parameter  int DP         = 4,
  parameter  int LINE_BEATS = 8,
  parameter  int TAG_W      = 27,
  localparam int IW         = $clog2(DP),
  localparam int BW         = $clog2(LINE_BEATS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              fifo_flush,
  output logic [IW-1:0]     tag_rptr,
  input  logic              tag_rvalid,
  input  logic              tag_rdirty,
  input  logic [TAG_W-1:0]  tag_rtag,
  output logic              tag_uwr,
  output logic [IW-1:0]     tag_uptr,
  output logic [TAG_W-1:0]  tag_utag,
  output logic              dmem_rd,
  output logic [IW+BW-1:0]  dmem_raddr,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [31:0]       wb_adr,
  output logic [31:0]       wb_dat,
  input  logic              wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_CLR  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [IW-1:0] IDX_LAST  = IW'(DP - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  state_t             state_r, state_s;
  logic [IW-1:0]      idx_r, idx_s;
  logic [BW-1:0]      beat_r, beat_s;
  logic [TAG_W-1:0]   tag_r, tag_s;
  logic [31:0]        wb_dat_r, wb_dat_s;

  // State and datapath registers; reset aborts any flush in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      idx_r    <= {IW{1'b0}};
      beat_r   <= {BW{1'b0}};
      tag_r    <= {TAG_W{1'b0}};
      wb_dat_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      beat_r   <= beat_s;
      tag_r    <= tag_s;
      wb_dat_r <= wb_dat_s;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    beat_s   = beat_r;
    tag_s    = tag_r;
    wb_dat_s = wb_dat_r;
    case (state_r)
      S_IDLE: begin
        if (flush_req) begin
          state_s = S_SCAN;
          idx_s   = {IW{1'b0}};
          beat_s  = {BW{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCAN: begin
        // Invalid entries are skipped even when their dirty bit is set.
        if (tag_rvalid && tag_rdirty) begin
          tag_s   = tag_rtag;
          state_s = S_RD;
        end else if (idx_r == IDX_LAST) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + IDX_ONE;
          state_s = S_SCAN;
        end
      end
      S_RD: begin
        state_s = S_CAP;
      end
      S_CAP: begin
        // Read data is valid the cycle after dmem_rd.
        wb_dat_s = dmem_rdata;
        state_s  = S_WR;
      end
      S_WR: begin
        if (wb_ack) begin
          if (beat_r == BEAT_LAST) begin
            beat_s  = {BW{1'b0}};
            state_s = S_CLR;
          end else begin
            beat_s  = beat_r + BEAT_ONE;
            state_s = S_RD;
          end
        end else begin
          state_s = S_WR;
        end
      end
      S_CLR: begin
        if (idx_r == IDX_LAST) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + IDX_ONE;
          state_s = S_SCAN;
        end
      end
      S_DONE: begin
        idx_s   = {IW{1'b0}};
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode; every output is a function of registered state only.
  always_comb begin
    flush_busy = (state_r != S_IDLE);
    flush_done = (state_r == S_DONE);
    fifo_flush = (state_r == S_DONE);
    tag_uwr    = (state_r == S_CLR);
    dmem_rd    = (state_r == S_RD);
    wb_stb     = (state_r == S_WR);
    wb_we      = (state_r == S_WR);
    tag_rptr   = idx_r;
    tag_uptr   = idx_r;
    tag_utag   = tag_r;
    dmem_raddr = {idx_r, beat_r};
    wb_adr     = {tag_r, beat_r, 2'b00};
    wb_dat     = wb_dat_r;
  end

endmodule

// File: tb/tb_dcache_flush_wb.sv
module tb_dcache_flush_wb;

  localparam int DP = 4;
  localparam int LB = 8;
  localparam int TW = 27;

  localparam int K_WR   = 0;
  localparam int K_CLR  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush_req;
  logic          flush_busy, flush_done, fifo_flush;
  logic [1:0]    tag_rptr;
  logic          tag_rvalid, tag_rdirty;
  logic [TW-1:0] tag_rtag;
  logic          tag_uwr;
  logic [1:0]    tag_uptr;
  logic [TW-1:0] tag_utag;
  logic          dmem_rd;
  logic [4:0]    dmem_raddr;
  logic [31:0]   dmem_rdata;
  logic          wb_stb, wb_we;
  logic [31:0]   wb_adr, wb_dat;
  logic          wb_ack;

  logic          m_valid [DP];
  logic          m_dirty [DP];
  logic [TW-1:0] m_tag   [DP];
  logic [31:0]   mem     [DP*LB];

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 0;
  int  ack_cnt = 0;
  int  wr_seen = 0;

  dcache_flush_wb #(.DP(DP), .LINE_BEATS(LB), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .fifo_flush(fifo_flush),
    .tag_rptr(tag_rptr), .tag_rvalid(tag_rvalid), .tag_rdirty(tag_rdirty),
    .tag_rtag(tag_rtag), .tag_uwr(tag_uwr), .tag_uptr(tag_uptr),
    .tag_utag(tag_utag), .dmem_rd(dmem_rd), .dmem_raddr(dmem_raddr),
    .dmem_rdata(dmem_rdata), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat(wb_dat), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  assign tag_rvalid = m_valid[tag_rptr];
  assign tag_rdirty = m_dirty[tag_rptr];
  assign tag_rtag   = m_tag[tag_rptr];

  // Data memory with one-cycle read latency.
  always @(posedge clk) begin
    if (dmem_rd) dmem_rdata <= mem[dmem_raddr];
  end

  // Bus slave: acknowledge after ack_delay wait cycles.
  always @(posedge clk) begin
    #1;
    if (wb_stb) begin
      if (ack_cnt >= ack_delay) begin
        wb_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        wb_ack = 1'b0;
        ack_cnt = ack_cnt + 1;
      end
    end else begin
      wb_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_ev(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected DUT event, queue size %0d at %0t", name, exp_q.size(), $time);
  endtask

  // Monitor: compare every bus beat, tag update and done pulse to the queue.
  always @(negedge clk) begin
    if (wb_stb) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_WR) begin
        fail_ev("wb_beat");
      end else begin
        chk("wb_adr", wb_adr, exp_q[0].a);
        chk("wb_dat", wb_dat, exp_q[0].d);
        chk("wb_we", {31'd0, wb_we}, 32'd1);
        if (wb_ack) begin
          void'(exp_q.pop_front());
          wr_seen++;
        end
      end
    end
    if (tag_uwr) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_CLR) begin
        fail_ev("tag_uwr");
      end else begin
        chk("tag_uptr", {30'd0, tag_uptr}, exp_q[0].a);
        chk("tag_utag", {5'd0, tag_utag}, exp_q[0].d);
        void'(exp_q.pop_front());
        m_valid[tag_uptr] = 1'b1;
        m_dirty[tag_uptr] = 1'b0;
        m_tag[tag_uptr]   = tag_utag;
      end
    end
    if (flush_done || fifo_flush) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_DONE) begin
        fail_ev("flush_done");
      end else begin
        chk("fifo_flush", {31'd0, fifo_flush}, 32'd1);
        chk("flush_done", {31'd0, flush_done}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic setup_clean();
    for (int i = 0; i < DP; i++) begin
      m_valid[i] = 1'b1;
      m_dirty[i] = 1'b0;
      m_tag[i]   = TW'(32'h100 + i);
    end
    for (int a = 0; a < DP*LB; a++) mem[a] = 32'hDEAD_0000 | a;
  endtask

  task automatic set_dirty(input int idx, input logic [TW-1:0] tag, input logic [31:0] base);
    m_valid[idx] = 1'b1;
    m_dirty[idx] = 1'b1;
    m_tag[idx]   = tag;
    for (int b = 0; b < LB; b++) mem[idx*LB + b] = base | b;
  endtask

  task automatic push_beats(input int idx, input logic [TW-1:0] tag, input logic [31:0] base,
                            input int nbeats);
    ev_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.kind = K_WR;
      e.a = {tag, 3'(b), 2'b00};
      e.d = base | b;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_line(input int idx, input logic [TW-1:0] tag, input logic [31:0] base);
    ev_t e;
    push_beats(idx, tag, base, LB);
    e.kind = K_CLR;
    e.a = idx;
    e.d = {5'd0, tag};
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.kind = K_DONE;
    e.a = 32'd0;
    e.d = 32'd0;
    exp_q.push_back(e);
  endtask

  // Pulse flush_req and time flush_done relative to the sampling edge.
  task automatic run_flush(input string name, input int exp_cyc, input bit mid_req);
    int  cyc;
    bit  done;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      flush_req = (mid_req && cyc == 2);
      chk({name, "_busy"}, {31'd0, flush_busy}, 32'd1);
      if (flush_done) done = 1'b1;
    end
    flush_req = 1'b0;
    if (!done) fail_ev({name, "_timeout"});
    chk({name, "_cycles"}, cyc, exp_cyc);
    @(negedge clk);
    chk({name, "_idle"}, {31'd0, flush_busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    flush_req = 1'b0;
    wb_ack = 1'b0;
    dmem_rdata = 32'd0;
    setup_clean();
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, flush_busy}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_uwr", {31'd0, tag_uwr}, 32'd0);
    chk("rst_done", {30'd0, flush_done, fifo_flush}, 32'd0);
    chk("rst_rptr", {30'd0, tag_rptr}, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_dat", wb_dat, 32'd0);
    chk("rst_dmem", {31'd0, dmem_rd}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all clean
    setup_clean();
    push_done();
    run_flush("t1_clean", 5, 1'b0);

    // 2: entry 2 dirty, immediate ack
    setup_clean();
    ack_delay = 0;
    set_dirty(2, 27'h1234, 32'h0000_00A0);
    push_line(2, 27'h1234, 32'h0000_00A0);
    push_done();
    run_flush("t2_line", 30, 1'b0);
    chk("t2_clean_after", {31'd0, m_dirty[2]}, 32'd0);

    // 3: same with three wait cycles per beat
    setup_clean();
    ack_delay = 3;
    set_dirty(2, 27'h1234, 32'h0000_00A0);
    push_line(2, 27'h1234, 32'h0000_00A0);
    push_done();
    run_flush("t3_wait", 54, 1'b0);

    // 4: entries 0 and 3 dirty, line 0 strictly first
    setup_clean();
    ack_delay = 0;
    set_dirty(0, 27'h00AB, 32'h0000_00B0);
    set_dirty(3, 27'h7FF_FFFF, 32'h0000_00C0);
    push_line(0, 27'h00AB, 32'h0000_00B0);
    push_line(3, 27'h7FF_FFFF, 32'h0000_00C0);
    push_done();
    run_flush("t4_two", 55, 1'b0);

    // 5: dirty-but-invalid skipped; second request while busy ignored
    setup_clean();
    m_valid[1] = 1'b0;
    m_dirty[1] = 1'b1;
    push_done();
    run_flush("t5_skip", 5, 1'b1);

    // 6: reset during beat 4, then restart from the beginning
    setup_clean();
    ack_delay = 0;
    wr_seen = 0;
    set_dirty(1, 27'h0555, 32'h0000_00D0);
    push_beats(1, 27'h0555, 32'h0000_00D0, 4);
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    guard = 0;
    while (!(wb_stb && wr_seen == 4) && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 200) fail_ev("t6_reach_beat4");
    reset_n = 1'b0;
    #1;
    chk("t6_stb_low", {31'd0, wb_stb}, 32'd0);
    chk("t6_beats_before", wr_seen, 32'd4);
    chk("t6_queue", exp_q.size(), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_rst_outs", {28'd0, flush_busy, tag_uwr, fifo_flush, flush_done}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rptr", {30'd0, tag_rptr}, 32'd0);
    chk("t6_dirty_kept", {31'd0, m_dirty[1]}, 32'd1);
    push_line(1, 27'h0555, 32'h0000_00D0);
    push_done();
    run_flush("t6_restart", 30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
